// File: rtl/interval_arbiter_pkg.sv
// Shared types and default widths for the interval arbiter slice.
package interval_arbiter_pkg;
    localparam int NREQ_DEF = 4;
    localparam int CW_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/interval_arbiter_if.sv
// Request/grant/status bundle between requesters and the interval arbiter.
interface interval_arbiter_if
    import interval_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int CW   = CW_DEF
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic                 enable;
    logic [NREQ-1:0]      req;
    logic [NREQ*CW-1:0]   len;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic                 done;
    logic [IW-1:0]        done_id;
    logic                 aborted;
    logic [CW-1:0]        counter_out;

    modport master (
        output enable, req, len,
        input  grant, busy, done, done_id, aborted, counter_out
    );

    modport slave (
        input  enable, req, len,
        output grant, busy, done, done_id, aborted, counter_out
    );
endinterface

// File: rtl/interval_arbiter_counter.sv
// Shared CW-bit up-counter; clear dominates increment.
module interval_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          sclr,
    input  logic          inc,
    output logic [CW-1:0] count
);
    always_ff @(posedge clk) begin
        if (sclr)
            count <= '0;
        else if (inc)
            count <= count + CW'(1);
    end
endmodule

// File: rtl/interval_arbiter.sv
// Round-robin owner of the shared interval counter.
// state | meaning
// IDLE  | counter held at 0, waiting for any req
// RUN   | grant[sel] high, counting enabled ticks up to latched target
// DONE  | one-cycle done pulse with done_id/aborted, counter cleared
module interval_arbiter
    import interval_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int CW   = CW_DEF
) (
    input logic               clk,
    input logic               reset,
    interval_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   nxt;
    logic [CW-1:0]   target;
    logic [CW-1:0]   count;
    logic [NREQ-1:0] grant;
    logic            busy;
    logic            done;
    logic [IW-1:0]   done_id;
    logic            aborted;
    logic            hit;
    logic            inc;
    logic            sclr;

    // Lowest offset from ptr+1 wins; offsets are walked high to low so the nearest sticks.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
        logic [IW-1:0] pick;
        int            idx;
        pick = p;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(p) + k) % NREQ;
            if (r[idx])
                pick = IW'(idx);
        end
        return pick;
    endfunction

    assign nxt  = rr_pick(bus.req, ptr);
    assign hit  = (count == target);
    assign inc  = (state == RUN) & bus.enable & ~hit;
    assign sclr = reset | (state != RUN);

    interval_counter #(.CW(CW)) u_counter (
        .clk   (clk),
        .sclr  (sclr),
        .inc   (inc),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= IW'(NREQ - 1);
            sel     <= '0;
            target  <= '0;
            grant   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= '0;
            aborted <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state  <= RUN;
                        sel    <= nxt;
                        ptr    <= nxt;
                        target <= bus.len[int'(nxt)*CW +: CW];
                        grant  <= NREQ'(1) << nxt;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    // Completion is checked first so a same-cycle req drop is not an abort.
                    if (hit && bus.enable) begin
                        state   <= DONE;
                        grant   <= '0;
                        done    <= 1'b1;
                        done_id <= sel;
                    end else if (!bus.req[sel]) begin
                        state   <= DONE;
                        grant   <= '0;
                        done    <= 1'b1;
                        done_id <= sel;
                        aborted <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant       = grant;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.done_id     = done_id;
    assign bus.aborted     = aborted;
    assign bus.counter_out = count;
endmodule

// File: tb/tb_interval_arbiter.sv
// Directed and randomized intervals checked against a transaction-level arbiter model.
module tb_interval_arbiter;
    localparam int NREQ = 4;
    localparam int CW   = 4;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   cyc_cnt = 0;
    int   last = NREQ - 1;

    interval_arbiter_if #(.NREQ(NREQ), .CW(CW)) bus ();

    interval_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next winner: first requester after the last one served, wrapping around.
    function automatic int model_pick(input logic [NREQ-1:0] pat);
        for (int i = 1; i <= NREQ; i++)
            if (pat[(last + i) % NREQ]) return (last + i) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ*CW-1:0] mk_len(input int l0, input int l1, input int l2, input int l3);
        logic [NREQ*CW-1:0] v;
        v = {CW'(l3), CW'(l2), CW'(l1), CW'(l0)};
        return v;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_grant"},   32'(bus.grant),       32'd0);
        check({tag, "_busy"},    32'(bus.busy),        32'd0);
        check({tag, "_done"},    32'(bus.done),        32'd0);
        check({tag, "_aborted"}, 32'(bus.aborted),     32'd0);
        check({tag, "_count"},   32'(bus.counter_out), 32'd0);
    endtask

    // Runs one interval starting from IDLE; returns RUN cycles until done and the grant time.
    task automatic run_interval(input logic [NREQ-1:0] pat, input logic [NREQ*CW-1:0] lens,
                                input int drop_at, input int en_pct, input int stall_at,
                                input int stall_n, output int n_run, output int g_time);
        int w, L, c, stall_left;
        bit e, r, finished, exp_ab;
        w = model_pick(pat);
        L = int'(lens[w*CW +: CW]);
        stall_left = stall_n;
        finished = 0;
        n_run = 0;
        bus.req = pat;
        bus.len = lens;
        bus.enable = 1'($urandom_range(1));
        @(posedge clk); #1;
        g_time = cyc_cnt;
        check("grant_on", 32'(bus.grant), 32'(1) << w);
        check("busy_on",  32'(bus.busy), 32'd1);
        check("count_start", 32'(bus.counter_out), 32'd0);
        check("done_idle", 32'(bus.done), 32'd0);
        last = w;
        c = 0;
        for (int cyc = 0; cyc < 64 && !finished; cyc++) begin
            e = ($urandom_range(99) < en_pct);
            if (c == stall_at && stall_left > 0) begin
                e = 0;
                stall_left--;
            end
            bus.enable = e;
            if (drop_at >= 0 && c == drop_at) bus.req[w] = 1'b0;
            bus.len = (NREQ*CW)'($urandom);
            r = bus.req[w];
            @(posedge clk); #1;
            n_run++;
            if (c == L && e) begin
                finished = 1; exp_ab = 0;
            end else if (!r) begin
                finished = 1; exp_ab = 1;
            end else begin
                if (e) c++;
                check("run_grant", 32'(bus.grant), 32'(1) << w);
                check("run_count", 32'(bus.counter_out), 32'(c));
                check("run_done",  32'(bus.done), 32'd0);
            end
            if (finished) begin
                check("done",       32'(bus.done), 32'd1);
                check("done_id",    32'(bus.done_id), 32'(w));
                check("aborted",    32'(bus.aborted), 32'(exp_ab));
                check("done_grant", 32'(bus.grant), 32'd0);
                check("done_busy",  32'(bus.busy), 32'd1);
            end
        end
        if (!finished) check("timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        check_quiet("idle");
    endtask

    initial begin
        int n, g, g_prev, w;
        reset = 1'b1;
        bus.req = '0;
        bus.len = '0;
        bus.enable = 1'b1;
        @(posedge clk); #1;
        bus.req = 4'b1111;
        @(posedge clk); #1;
        check_quiet("reset");
        check("reset_done_id", 32'(bus.done_id), 32'd0);
        reset = 1'b0;

        // Requester 0, len 3: done five cycles after the request.
        run_interval(4'b0001, mk_len(3, 9, 9, 9), -1, 100, -1, 0, n, g);
        check("lat_basic", 32'(n + 1), 32'd5);

        // All requesting with len 0: grants rotate, 3 cycles from grant to grant.
        g_prev = -1;
        for (int i = 0; i < 5; i++) begin
            run_interval(4'b1111, mk_len(0, 0, 0, 0), -1, 100, -1, 0, n, g);
            if (g_prev >= 0) check("rot_spacing", 32'(g - g_prev), 32'd3);
            g_prev = g;
        end

        // Requester 2 aborts at count 6.
        run_interval(4'b0100, mk_len(0, 0, 15, 0), 6, 100, -1, 0, n, g);
        check("abort_lat", 32'(n), 32'd7);

        // Requester 1, len 4, stalled 3 cycles at count 2.
        run_interval(4'b0010, mk_len(0, 4, 0, 0), -1, 100, 2, 3, n, g);
        check("stall_lat", 32'(n), 32'd8);

        // Target hit and req drop together: completion.
        run_interval(4'b0001, mk_len(2, 0, 0, 0), 2, 100, -1, 0, n, g);

        // Reset at count 5 discards the interval.
        bus.req = 4'b0001;
        bus.len = mk_len(10, 0, 0, 0);
        bus.enable = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.counter_out !== 4'd5 && n < 30);
        check("reach_5", 32'(bus.counter_out), 32'd5);
        reset = 1'b1;
        @(posedge clk); #1;
        check_quiet("midreset");
        reset = 1'b0;
        bus.req = '0;
        last = NREQ - 1;
        @(posedge clk); #1;
        check_quiet("post_reset");
        run_interval(4'b1001, mk_len(1, 0, 0, 1), -1, 100, -1, 0, n, g);
        run_interval(4'b1000, mk_len(0, 0, 0, 2), -1, 100, -1, 0, n, g);

        // Randomized intervals.
        for (int i = 0; i < 40; i++) begin
            logic [NREQ-1:0] pat;
            pat = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            w = $urandom_range(0, 9);
            run_interval(pat, (NREQ*CW)'($urandom), (w > 7) ? -1 : w, 70, -1, 0, n, g);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
